// File: rtl/line_burst_ctrl.sv
// -----------------------------------------------------------------------------
// line_burst_ctrl
//
// Purpose:
//   Converts a single 256-bit line request from an arbiter into a burst of
//   64-bit beats towards memory. A read burst collects BEATS beats from
//   burst_i into line_o. A write burst serves the latched line one lane at a
//   time on burst_o. After the last beat is accepted the block spends one
//   cycle in DONE, pulsing resp_o, and then returns to IDLE.
//
//   Lane k of a line is bits [64k+63:64k]. Beats are transferred in lane order
//   0..BEATS-1. A cycle with resp_i low in RD/WR is a stall.
//
// Parameters:
//   BEATS      64-bit beats per 256-bit line. Only 4 is supported.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-low reset
//   -- arbiter side --
//   read_i     line read request, held until resp_o
//   write_i    line write request, held until resp_o (a read wins if both)
//   address_i  line address (the low 5 bits are ignored)
//   line_i     write line
//   resp_o     one-cycle completion pulse (asserted in DONE)
//   line_o     assembled read line, valid from DONE until the next read beat
//   busy_o     high in RD, WR and DONE
//   -- memory side --
//   read_o     burst read request (high in RD)
//   write_o    burst write request (high in WR)
//   address_o  line-aligned burst address, 0 in IDLE
//   burst_o    current write beat, 0 outside WR
//   burst_i    read beat
//   resp_i     beat-valid (read) / beat-accepted (write) strobe
//
// Every output comes straight from a flop. The next-state logic computes the
// next value of each output from the next state and counter, so the outputs
// line up with the state they describe and never glitch.
// -----------------------------------------------------------------------------
module line_burst_ctrl #(
    parameter int BEATS = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [31:0]           address_i,
    input  logic [BEATS*64-1:0]   line_i,
    output logic                  resp_o,
    output logic [BEATS*64-1:0]   line_o,
    output logic                  busy_o,

    output logic                  read_o,
    output logic                  write_o,
    output logic [31:0]           address_o,
    output logic [63:0]           burst_o,
    input  logic [63:0]           burst_i,
    input  logic                  resp_i
);

    localparam int BEAT_W = 64;
    localparam int LINE_W = BEATS * BEAT_W;
    localparam int CNT_W  = $clog2(BEATS);

    // Index of the final beat of a burst. Accepting it ends the burst.
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0]   wbuf_q,    wbuf_d;
    logic [LINE_W-1:0]   line_q,    line_d;
    logic [31:0]         addr_q,    addr_d;

    // Registered outputs
    logic                resp_q,    resp_d;
    logic                busy_q,    busy_d;
    logic                rd_q,      rd_d;
    logic                wr_q,      wr_d;
    logic [BEAT_W-1:0]   burst_q,   burst_d;

    // The low address bits only select a byte within the line, and a line
    // transfer always starts at the line boundary, so those bits are dropped.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^address_i[4:0];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d gets its hold value first, so any path through the
        // case below that does not assign it keeps the flop value instead of
        // inferring a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        wbuf_d     = wbuf_q;
        line_d     = line_q;
        addr_d     = addr_q;

        unique case (state_q)
            IDLE: begin
                // A read wins over a simultaneous write; the write is simply
                // not started and the requester sees resp_o for the read.
                if (read_i || write_i) begin
                    state_d    = read_i ? RD : WR;
                    addr_d     = {address_i[31:5], 5'b0};
                    wbuf_d     = line_i;
                    beat_cnt_d = '0;
                end
            end

            RD: begin
                if (resp_i) begin
                    // line_o is written lane by lane, so it keeps the previous
                    // read's data until this burst's first beat arrives.
                    line_d[BEAT_W*int'(beat_cnt_q) +: BEAT_W] = burst_i;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            WR: begin
                if (resp_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // The requester drops its request by now; address_o returns
                // to 0 together with the return to IDLE.
                state_d = IDLE;
                addr_d  = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Output values for the cycle after this edge, derived from the
        // state being entered rather than the one being left.
        rd_d    = (state_d == RD);
        wr_d    = (state_d == WR);
        busy_d  = (state_d != IDLE);
        resp_d  = (state_d == DONE);
        burst_d = (state_d == WR) ? wbuf_d[BEAT_W*int'(beat_cnt_d) +: BEAT_W]
                                  : '0;
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: all state is updated with non-blocking assignments so that every
    // flop samples the pre-edge values computed above, independent of the
    // order of statements in this block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the line and write buffers are ordinary flops rather than
            // a RAM, so they can and do clear on reset; a stale line must not
            // reach line_o after an aborted read.
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            wbuf_q     <= '0;
            line_q     <= '0;
            addr_q     <= '0;
            resp_q     <= 1'b0;
            busy_q     <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wbuf_q     <= wbuf_d;
            line_q     <= line_d;
            addr_q     <= addr_d;
            resp_q     <= resp_d;
            busy_q     <= busy_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            burst_q    <= burst_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign resp_o    = resp_q;
    assign line_o    = line_q;
    assign busy_o    = busy_q;
    assign read_o    = rd_q;
    assign write_o   = wr_q;
    assign address_o = addr_q;
    assign burst_o   = burst_q;

endmodule
